icache_direct: RTL and testbench

- Direct-mapped instruction cache directly upstream of the instruction-fetch stage.
- Accepts a fetch PC with a request flag and returns the 32-bit instruction with a one-cycle valid pulse.
- On a miss, refills a whole line one word at a time from the memory controller's word port.
- Read-only; no flush, no self-modifying-code support.

---
 rtl/icache_direct_pkg.sv | 35 +++
 rtl/icache_refill_fsm.sv | 107 ++++++++++
 rtl/icache_direct.sv | 125 ++++++++++++
 tb/tb_icache_direct.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   - default geometry (line count, words per line)
//   - refill state encoding
//   - helpers for tag/index/offset slice bounds of a 32-bit byte address
package icache_direct_pkg;

    localparam int unsigned DefIndexW = 5;  // 32 lines
    localparam int unsigned DefOffsW  = 2;  // 4 words per line

    typedef enum logic {
        StIdle   = 1'b0,
        StRefill = 1'b1
    } refill_state_e;

    function automatic int unsigned tag_width(input int unsigned index_w,
                                              input int unsigned offs_w);
        return 32 - index_w - offs_w - 2;
    endfunction

    // Lowest pc bit of the line index (just above word offset and byte bits).
    function automatic int unsigned index_lo(input int unsigned offs_w);
        return offs_w + 2;
    endfunction

    function automatic int unsigned index_hi(input int unsigned index_w,
                                             input int unsigned offs_w);
        return offs_w + index_w + 1;
    endfunction

    function automatic int unsigned tag_lo(input int unsigned index_w,
                                           input int unsigned offs_w);
        return index_w + offs_w + 2;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill engine for icache_direct.
// Fetches one cache line word by word from the memory controller and
// presents the assembled line with a single-cycle write strobe.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   rdy            global ready; low freezes all state
//   start          miss detected in the lookup stage (honoured only when idle)
//   start_base     line-aligned byte address of the missing line
//   mem_done       mem_data valid; consumes the current word request
//   mem_data       returned word
//   busy           refill in progress
//   mem_req        word read request, held high for the whole line
//   mem_addr       current word address
//   miss_base      latched line address (source of write index/tag)
//   line_wr        line complete; write line_data this edge
//   line_data      full line: buffered words plus the final word in flight
module icache_refill_fsm
    import icache_direct_pkg::*;
#(
    parameter int unsigned OFFS_W = DefOffsW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           start,
    input  logic [31:0]                    start_base,
    input  logic                           mem_done,
    input  logic [31:0]                    mem_data,
    output logic                           busy,
    output logic                           mem_req,
    output logic [31:0]                    mem_addr,
    output logic [31:0]                    miss_base,
    output logic                           line_wr,
    output logic [(2**OFFS_W)-1:0][31:0]   line_data
);

    localparam logic [OFFS_W-1:0] CntLast = '1;

    refill_state_e                  state_q;
    logic [OFFS_W-1:0]              cnt_q;
    logic [31:0]                    base_q;
    logic                           mem_req_q;
    logic [31:0]                    mem_addr_q;
    logic [(2**OFFS_W)-1:0][31:0]   line_buf_q;

    logic [OFFS_W-1:0]              cnt_inc;
    logic                           last_word;
    logic [31:0]                    next_addr;
    logic                           word_take;

    assign cnt_inc   = cnt_q + 1'b1;
    assign last_word = (cnt_q == CntLast);
    // 32-bit add so a line at the top of the address space wraps cleanly.
    assign next_addr = base_q + {{(30 - OFFS_W){1'b0}}, cnt_inc, 2'b00};
    // A mem_done seen while rdy is low is not consumed.
    assign word_take = (state_q == StRefill) && rdy && mem_done;

    assign line_wr   = word_take && last_word;
    assign busy      = (state_q == StRefill);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign miss_base = base_q;

    // The last word goes straight from mem_data into the array write.
    always_comb begin
        line_data          = line_buf_q;
        line_data[CntLast] = mem_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            base_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            line_buf_q <= '0;
        end else if (rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q     <= start_base;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= start_base;
                        state_q    <= StRefill;
                    end
                end
                StRefill: begin
                    if (mem_done) begin
                        line_buf_q[cnt_q] <= mem_data;
                        if (last_word) begin
                            cnt_q     <= '0;
                            mem_req_q <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q      <= cnt_inc;
                            mem_addr_q <= next_addr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache in front of the fetch stage.
// A hit returns the word one edge after the request with a one-cycle
// ins_flag pulse; a miss refills the whole line, then the re-lookup hits.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   rdy        global ready; low freezes all state
//   pc         word-aligned fetch address
//   pc_flag    fetch request (level, held until ins_flag)
//   ins        instruction for pc
//   ins_flag   one-cycle pulse, ins valid
//   mem_req    word read request to the memory controller
//   mem_addr   word-aligned refill address
//   mem_data   returned word
//   mem_done   mem_data valid; consumes the current request
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int unsigned INDEX_W = DefIndexW,
    parameter int unsigned OFFS_W  = DefOffsW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc,
    input  logic        pc_flag,
    output logic [31:0] ins,
    output logic        ins_flag,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_done
);

    localparam int unsigned TagW      = tag_width(INDEX_W, OFFS_W);
    localparam int unsigned Lines     = 2**INDEX_W;
    localparam int unsigned LineWords = 2**OFFS_W;
    localparam int unsigned IdxLo     = index_lo(OFFS_W);
    localparam int unsigned IdxHi     = index_hi(INDEX_W, OFFS_W);
    localparam int unsigned TagLo     = tag_lo(INDEX_W, OFFS_W);

    logic [Lines-1:0]                valid_q;
    logic [TagW-1:0]                 tag_q  [Lines];
    logic [LineWords-1:0][31:0]      data_q [Lines];
    logic [31:0]                     ins_q;
    logic                            ins_flag_q;

    logic [OFFS_W-1:0]               offset;
    logic [INDEX_W-1:0]              index;
    logic [TagW-1:0]                 tag;
    logic                            hit;
    logic                            lookup;
    logic                            start;
    logic [31:0]                     start_base;

    logic                            busy;
    logic [31:0]                     miss_base;
    logic                            line_wr;
    logic [LineWords-1:0][31:0]      line_data;
    logic [INDEX_W-1:0]              wr_index;
    logic [TagW-1:0]                 wr_tag;

    logic                            unused_bits;

    assign offset     = pc[IdxLo-1:2];
    assign index      = pc[IdxHi:IdxLo];
    assign tag        = pc[31:TagLo];
    assign start_base = {pc[31:IdxLo], {IdxLo{1'b0}}};

    assign wr_index   = miss_base[IdxHi:IdxLo];
    assign wr_tag     = miss_base[31:TagLo];

    assign hit    = valid_q[index] && (tag_q[index] == tag);
    // ins_flag guard stops the held request from being served twice.
    assign lookup = rdy && !busy && pc_flag && !ins_flag_q;
    assign start  = lookup && !hit;

    assign ins      = ins_q;
    assign ins_flag = ins_flag_q;

    assign unused_bits = ^{pc[1:0], miss_base[IdxLo-1:0]};

    icache_refill_fsm #(
        .OFFS_W (OFFS_W)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .start      (start),
        .start_base (start_base),
        .mem_done   (mem_done),
        .mem_data   (mem_data),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .miss_base  (miss_base),
        .line_wr    (line_wr),
        .line_data  (line_data)
    );

    // Hit path and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            ins_q      <= '0;
            ins_flag_q <= 1'b0;
        end else if (rdy) begin
            ins_flag_q <= lookup && hit;
            if (lookup && hit) begin
                ins_q <= data_q[index][offset];
            end
            if (line_wr) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q guards them.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= line_data;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] pc;
    logic        pc_flag;
    logic [31:0] ins;
    logic        ins_flag;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_ins[$];

    icache_direct dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .pc       (pc),
        .pc_flag  (pc_flag),
        .ins      (ins),
        .ins_flag (ins_flag),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_done (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + (a >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Memory controller model: mem_done two cycles after each request,
    // held while rdy is low.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_done = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_done = 1'b0;
                wait_cnt = 0;
            end else if (mem_done) begin
                if (rdy) begin
                    mem_done = 1'b0;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    mem_done = 1'b1;
                    mem_data = mem_word(mem_addr);
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        logic        prev_flag;
        logic [31:0] e;
        prev_flag = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (ins_flag) begin
                    check("ins_flag_pulse", {31'b0, prev_flag}, 32'd0);
                    if (exp_ins.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ins_unexpected: got ins=%h, none expected", ins);
                    end else begin
                        e = exp_ins.pop_front();
                        check("ins", ins, e);
                    end
                end
                if (mem_req && mem_done && rdy) begin
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL addr_unexpected: got mem_addr=%h, none expected", mem_addr);
                    end else begin
                        e = exp_addr.pop_front();
                        check("mem_addr", mem_addr, e);
                    end
                end
                prev_flag = ins_flag;
            end else begin
                prev_flag = 1'b0;
            end
        end
    end

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(i * 4));
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        check("queue_drain", 32'(exp_addr.size() + exp_ins.size()), 32'd0);
        exp_addr.delete();
        exp_ins.delete();
    endtask

    // One fetch: optional redirect after N consumed words, optional rdy
    // stall when word N (0-based count of consumed words) is presented.
    task automatic run_fetch(input logic [31:0] a, input logic [31:0] redir_a,
                             input int redir_after, input int stall_at, input int exp_lat);
        int          dones;
        bit          done, pend, redirected, stalled, saw_req;
        logic [31:0] addr0;
        dones = 0; done = 0; pend = 0; redirected = 0; stalled = 0; saw_req = 0;
        @(negedge clk);
        pc      = a;
        pc_flag = 1'b1;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge clk);
            if (mem_req) saw_req = 1;
            if (ins_flag) begin
                pc_flag = 1'b0;
                done    = 1;
                check("mem_req_low_at_ins", {31'b0, mem_req}, 32'd0);
                if (exp_lat > 0) begin
                    check("hit_latency", 32'(cyc), 32'(exp_lat));
                    check("hit_no_mem_req", {31'b0, saw_req}, 32'd0);
                end
            end else begin
                if (pend && !redirected) begin
                    pc         = redir_a;
                    redirected = 1;
                end
                if (stall_at > 0 && !stalled && dones == stall_at && mem_done && mem_req) begin
                    stalled = 1;
                    addr0   = mem_addr;
                    rdy     = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check("stall_addr", mem_addr, addr0);
                        check("stall_ins_flag", {31'b0, ins_flag}, 32'd0);
                        check("stall_mem_req", {31'b0, mem_req}, 32'd1);
                    end
                    rdy = 1'b1;
                end
                if (mem_done && mem_req) begin
                    dones++;
                    if (redir_after > 0 && dones == redir_after) pend = 1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: got no ins_flag for pc=%h, required one", a);
            pc_flag = 1'b0;
        end
    endtask

    initial begin
        int dones;
        bit fired;
        rst     = 1'b0;
        rdy     = 1'b1;
        pc      = '0;
        pc_flag = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ins", ins, 32'd0);
        check("rst_ins_flag", {31'b0, ins_flag}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // Cold miss at 0x4.
        push_line(32'h0000_0000);
        exp_ins.push_back(32'h0000_00A1);
        run_fetch(32'h0000_0004, '0, 0, 0, 0);
        drain();

        // Hit after fill.
        exp_ins.push_back(32'h0000_00A3);
        run_fetch(32'h0000_000C, '0, 0, 0, 1);
        drain();

        // Conflict eviction on index 0.
        push_line(32'h0000_0200);
        exp_ins.push_back(32'h0000_0120);
        run_fetch(32'h0000_0200, '0, 0, 0, 0);
        drain();

        // 0x0 misses again; redirect to 0x40 after the second word.
        push_line(32'h0000_0000);
        push_line(32'h0000_0040);
        exp_ins.push_back(32'h0000_00B0);
        run_fetch(32'h0000_0000, 32'h0000_0040, 2, 0, 0);
        drain();

        // The completed 0x0 line is resident.
        exp_ins.push_back(32'h0000_00A0);
        run_fetch(32'h0000_0000, '0, 0, 0, 1);
        drain();

        // rdy stall with mem_done held.
        push_line(32'h0000_0080);
        exp_ins.push_back(32'h0000_00C0);
        run_fetch(32'h0000_0080, '0, 0, 1, 0);
        drain();

        // Line at the top of the address space.
        push_line(32'hFFFF_FFF0);
        exp_ins.push_back(32'h4000_009E);
        run_fetch(32'hFFFF_FFF8, '0, 0, 0, 0);
        drain();

        // Async reset after the first word of a refill.
        exp_addr.push_back(32'h0000_0200);
        @(negedge clk);
        pc      = 32'h0000_0200;
        pc_flag = 1'b1;
        dones   = 0;
        fired   = 0;
        for (int cyc = 0; cyc < 100 && !fired; cyc++) begin
            @(negedge clk);
            if (dones >= 1 && !mem_done) begin
                fired = 1;
                #3;
                rst     = 1'b1;
                pc_flag = 1'b0;
                #1;
                check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
                check("async_rst_mem_addr", mem_addr, 32'd0);
                check("async_rst_ins_flag", {31'b0, ins_flag}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end else if (mem_done && mem_req) begin
                dones++;
            end
        end
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL reset_refill_timeout: got %0d words, required 1", dones);
            rst = 1'b0;
        end
        drain();

        // Valid bits cleared: 0x0 refills from 0x0.
        push_line(32'h0000_0000);
        exp_ins.push_back(32'h0000_00A0);
        run_fetch(32'h0000_0000, '0, 0, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
